// File: rtl/seg7_scan_driver_if.sv
// Bus between the counter side and the 7-segment scan driver.
// The master drives the word to show and the display controls. The slave (the driver)
// returns the active-low anode and segment lines and the frame pulse.
interface seg7_scan_driver_if;
  logic [15:0] value;       // word to display
  logic        disp_en;     // 1 = display on
  logic        blank_lz;    // 1 = blank leading zero digits
  logic [3:0]  an;          // anode enables, active-low, an[0] = LS digit
  logic [6:0]  seg;         // segments {g,f,e,d,c,b,a}, active-low
  logic        dp;          // decimal point, active-low (always off)
  logic        frame_tick;  // one-cycle pulse on snapshot load

  modport master (
    output value, disp_en, blank_lz,
    input  an, seg, dp, frame_tick
  );

  modport slave (
    input  value, disp_en, blank_lz,
    output an, seg, dp, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 4-digit hex driver for a common-anode 7-segment display.
// A prescaler paces the digit slots. The displayed word is snapshotted once per
// frame (at the end of digit 3) so the digits never tear while the source counts.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000  // clk cycles per digit slot, >= 2
) (
  input  logic               clk,
  input  logic               reset,
  seg7_scan_driver_if.slave  bus
);

  localparam int              PW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0]   PCNT_LAST = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   snap_q, snap_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          frame_tick_q, frame_tick_d;

  logic          tick;
  logic [3:0]    nib;
  logic          upper_zero;
  logic          blank;

  // Hex digit to active-low gfedcba pattern.
  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0:    hex7 = 7'b1000000;
      4'h1:    hex7 = 7'b1111001;
      4'h2:    hex7 = 7'b0100100;
      4'h3:    hex7 = 7'b0110000;
      4'h4:    hex7 = 7'b0011001;
      4'h5:    hex7 = 7'b0010010;
      4'h6:    hex7 = 7'b0000010;
      4'h7:    hex7 = 7'b1111000;
      4'h8:    hex7 = 7'b0000000;
      4'h9:    hex7 = 7'b0010000;
      4'hA:    hex7 = 7'b0001000;
      4'hB:    hex7 = 7'b0000011;
      4'hC:    hex7 = 7'b1000110;
      4'hD:    hex7 = 7'b0100001;
      4'hE:    hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  assign tick = (pcnt_q == PCNT_LAST);

  // Prescaler, digit index and once-per-frame snapshot of the input word.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    pcnt_d       = pcnt_q + PW'(1);
    idx_d        = idx_q;
    snap_d       = snap_q;
    frame_tick_d = 1'b0;
    if (tick) begin
      pcnt_d = '0;
      idx_d  = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        snap_d       = bus.value;
        frame_tick_d = 1'b1;
      end
    end
  end

  // Output stage: decode the current digit, or blank it when off / a leading zero.
  always_comb begin
    nib = snap_q[{idx_q, 2'b00} +: 4];
    case (idx_q)
      2'd1:    upper_zero = (snap_q[15:4]  == 12'h000);
      2'd2:    upper_zero = (snap_q[15:8]  == 8'h00);
      2'd3:    upper_zero = (snap_q[15:12] == 4'h0);
      default: upper_zero = 1'b0;  // digit 0 is never zero-blanked
    endcase
    blank = !bus.disp_en || (bus.blank_lz && upper_zero);
    an_d  = ~(4'b0001 << idx_q);
    seg_d = hex7(nib);
    if (blank) begin
      an_d  = 4'b1111;
      seg_d = 7'b1111111;
    end
  end

  // All state, asynchronously cleared to the dark, idx 0 condition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt_q       <= '0;
      idx_q        <= 2'd0;
      snap_q       <= 16'h0000;
      an_q         <= 4'b1111;
      seg_q        <= 7'b1111111;
      frame_tick_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      pcnt_q       <= pcnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = 1'b1;
  assign bus.frame_tick = frame_tick_q;

endmodule
